// File: rtl/mg_pkg.sv
// Shared memory-game definitions: regfile entry layout, card states and the pair-judge FSM encoding.
package mg_pkg;

    localparam int COLOR_W     = 12;
    localparam int CARD_ADDR_W = 4;
    localparam int ENTRY_W     = COLOR_W + 2;

    localparam logic [1:0] CARD_FACE_DOWN = 2'b00;
    localparam logic [1:0] CARD_MATCHED   = 2'b10;
    localparam logic [1:0] CARD_FACE_UP   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_RD_A        = 4'd1,
        S_WAIT_SECOND = 4'd2,
        S_RD_B        = 4'd3,
        S_CMP         = 4'd4,
        S_WR_MATCH_A  = 4'd5,
        S_WR_MATCH_B  = 4'd6,
        S_HIDE_WAIT   = 4'd7,
        S_WR_HIDE_A   = 4'd8,
        S_WR_HIDE_B   = 4'd9
    } judge_state_e;

endpackage

// File: rtl/hide_timer.sv
// Load/count-down timer that keeps a mismatched pair visible; expired is high while the count is zero.
module hide_timer #(
    parameter int DELAY = 65_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int TW = (DELAY > 1) ? $clog2(DELAY) : 1;

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = TW'(DELAY - 1);
        end else if (en && (count_q != '0)) begin
            count_d = count_q - TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/card_pair_judge.sv
// Pairs two clicked cards and writes MATCHED, or FACE_DOWN after a visible delay, back to the regfile.
// Defining PAIR_JUDGE_MOVE_CNT_EN adds a saturating move_cnt output counting comparisons.
module card_pair_judge
    import mg_pkg::*;
#(
    parameter int NUM_CARDS  = 16,
    parameter int HIDE_DELAY = 65_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   new_game,
    input  logic                   card_pressed,
    input  logic [CARD_ADDR_W-1:0] card_address,
    output logic [CARD_ADDR_W-1:0] rd_address,
    input  logic [ENTRY_W-1:0]     rd_data,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [CARD_ADDR_W-1:0] wr_address,
    output logic [ENTRY_W-1:0]     wr_data,
    output logic                   busy,
    output logic                   pair_matched,
    output logic                   game_over,
    output judge_state_e           state_dbg
`ifdef PAIR_JUDGE_MOVE_CNT_EN
    ,
    output logic [9:0]             move_cnt
`endif
);

    localparam int PAIRS = NUM_CARDS / 2;
    localparam int CW    = $clog2(PAIRS + 1);

    judge_state_e           state_q, state_d;
    logic [CARD_ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [COLOR_W-1:0]     color_a_q, color_a_d, color_b_q, color_b_d;
    logic [CW-1:0]          pair_cnt_q, pair_cnt_d;
    logic                   game_over_q, game_over_d;
    logic                   pair_matched_q, pair_matched_d;
    logic                   timer_load, timer_en, timer_expired;
    logic                   unused_rd_state;

    assign unused_rd_state = ^rd_data[1:0];

    hide_timer #(.DELAY(HIDE_DELAY)) u_hide_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (new_game),
        .load    (timer_load),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // Write port: wr_valid/wr_address/wr_data are held stable until the cycle wr_ready is high;
    // a write completes on the clock edge where wr_valid && wr_ready, and the FSM advances then.
    always_comb begin
        state_d        = state_q;
        addr_a_d       = addr_a_q;
        addr_b_d       = addr_b_q;
        color_a_d      = color_a_q;
        color_b_d      = color_b_q;
        pair_cnt_d     = pair_cnt_q;
        game_over_d    = game_over_q;
        pair_matched_d = 1'b0;
        timer_load     = 1'b0;
        timer_en       = 1'b0;
        rd_address     = '0;
        wr_valid       = 1'b0;
        wr_address     = '0;
        wr_data        = '0;

        unique case (state_q)
            S_IDLE: begin
                if (card_pressed && !game_over_q) begin
                    addr_a_d   = card_address;
                    rd_address = card_address;
                    state_d    = S_RD_A;
                end
            end
            S_RD_A: begin
                color_a_d = rd_data[ENTRY_W-1:2];
                state_d   = S_WAIT_SECOND;
            end
            S_WAIT_SECOND: begin
                if (card_pressed && (card_address != addr_a_q)) begin
                    addr_b_d   = card_address;
                    rd_address = card_address;
                    state_d    = S_RD_B;
                end
            end
            S_RD_B: begin
                color_b_d = rd_data[ENTRY_W-1:2];
                state_d   = S_CMP;
            end
            S_CMP: begin
                if (color_a_q == color_b_q) begin
                    state_d = S_WR_MATCH_A;
                end else begin
                    timer_load = 1'b1;
                    state_d    = S_HIDE_WAIT;
                end
            end
            S_HIDE_WAIT: begin
                timer_en = 1'b1;
                if (timer_expired) state_d = S_WR_HIDE_A;
            end
            S_WR_MATCH_A, S_WR_HIDE_A: begin
                wr_valid   = 1'b1;
                wr_address = addr_a_q;
                wr_data    = {color_a_q, (state_q == S_WR_MATCH_A) ? CARD_MATCHED : CARD_FACE_DOWN};
                if (wr_ready) state_d = (state_q == S_WR_MATCH_A) ? S_WR_MATCH_B : S_WR_HIDE_B;
            end
            S_WR_MATCH_B, S_WR_HIDE_B: begin
                wr_valid   = 1'b1;
                wr_address = addr_b_q;
                wr_data    = {color_b_q, (state_q == S_WR_MATCH_B) ? CARD_MATCHED : CARD_FACE_DOWN};
                if (wr_ready) begin
                    state_d = S_IDLE;
                    if (state_q == S_WR_MATCH_B) begin
                        pair_matched_d = 1'b1;
                        if (pair_cnt_q < CW'(PAIRS)) pair_cnt_d = pair_cnt_q + CW'(1);
                        if (pair_cnt_d == CW'(PAIRS)) game_over_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new game overrides anything decoded above, including a half-finished write.
        if (new_game) begin
            state_d        = S_IDLE;
            addr_a_d       = addr_a_q;
            pair_cnt_d     = '0;
            game_over_d    = 1'b0;
            pair_matched_d = 1'b0;
            rd_address     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            addr_a_q       <= '0;
            addr_b_q       <= '0;
            color_a_q      <= '0;
            color_b_q      <= '0;
            pair_cnt_q     <= '0;
            game_over_q    <= 1'b0;
            pair_matched_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_a_q       <= addr_a_d;
            addr_b_q       <= addr_b_d;
            color_a_q      <= color_a_d;
            color_b_q      <= color_b_d;
            pair_cnt_q     <= pair_cnt_d;
            game_over_q    <= game_over_d;
            pair_matched_q <= pair_matched_d;
        end
    end

    assign busy         = (state_q != S_IDLE) && (state_q != S_WAIT_SECOND);
    assign pair_matched = pair_matched_q;
    assign game_over    = game_over_q;
    assign state_dbg    = state_q;

`ifdef PAIR_JUDGE_MOVE_CNT_EN
    logic [9:0] move_cnt_q, move_cnt_d;

    always_comb begin
        move_cnt_d = move_cnt_q;
        if (new_game) begin
            move_cnt_d = '0;
        end else if ((state_q == S_CMP) && (move_cnt_q != 10'h3FF)) begin
            move_cnt_d = move_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            move_cnt_q <= '0;
        end else begin
            move_cnt_q <= move_cnt_d;
        end
    end

    assign move_cnt = move_cnt_q;
`endif

endmodule
